// File: rtl/hs_tx_arbiter.sv
// hs_tx_arbiter: round-robin arbiter feeding one byte per grant to a handshake sender,
// with per-transfer timeout, sticky error flag and a wrapping success counter.
module hs_tx_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [3:0]  req,
  input  logic [31:0] reqdata,
  input  logic        aready,
  input  logic        anxtdata,
  output logic [7:0]  adatain,
  output logic        asend,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        timeout,
  output logic        err,
  output logic [15:0] xfer_cnt
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_e      state_q;
  logic [1:0]  ptr_q, own_q, win_d;
  logic [7:0]  wcnt_q, data_q;
  logic [3:0]  grant_q, done_q;
  logic        asend_q, timeout_q, err_q;
  logic [15:0] cnt_q;
  // Walk offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    win_d = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (req[ptr_q + 2'(k)]) win_d = ptr_q + 2'(k);
  end
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      wcnt_q    <= '0;
      data_q    <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      asend_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      asend_q   <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (aready && |req) begin
          own_q   <= win_d;
          grant_q <= 4'b0001 << win_d;
          data_q  <= reqdata[8*win_d +: 8];
          asend_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wcnt_q <= wcnt_q + 8'd1;
          if (anxtdata || wcnt_q == LAST) begin
            grant_q <= '0;
            ptr_q   <= own_q + 2'd1;
            state_q <= IDLE;
            if (anxtdata) begin
              done_q <= grant_q;
              cnt_q  <= cnt_q + 16'd1;
            end else begin
              timeout_q <= 1'b1;
              err_q     <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign adatain  = data_q;
  assign asend    = asend_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign err      = err_q;
  assign xfer_cnt = cnt_q;
endmodule
